// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM states,
// active-high 7-segment glyphs and a digit-to-glyph lookup.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit order gfedcba, bit 0 = segment a, segment on = 1.
  localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK   = 7'h00;

  // Non-decimal codes 10..15 render dark, same as a blanked digit.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_GLYPH_0;
      4'd1:    g = SEG_GLYPH_1;
      4'd2:    g = SEG_GLYPH_2;
      4'd3:    g = SEG_GLYPH_3;
      4'd4:    g = SEG_GLYPH_4;
      4'd5:    g = SEG_GLYPH_5;
      4'd6:    g = SEG_GLYPH_6;
      4'd7:    g = SEG_GLYPH_7;
      4'd8:    g = SEG_GLYPH_8;
      4'd9:    g = SEG_GLYPH_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_seg7.sv
// One BCD digit to seven segments, with blanking and selectable output polarity.
module bin2bcd_seq_seg7
  import bin2bcd_seq_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_raw;

  always_comb begin
    seg_raw = blank_i ? SEG_BLANK : seg_glyph(bcd_i);
    // Inversion also applies to the blank state, so a blank digit is all-ones when active-low.
    seg_o   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with overflow saturation, leading-zero blanking and per-digit 7-segment outputs.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int W              = 10,
  parameter int DIGITS         = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          bin_in,
  input  logic                  lz_blank,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * DIGITS;

  // Handshake: a request is taken on any rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE. out_valid is a one-cycle pulse with no back-pressure.

  state_e            state_q, state_d;
  logic [W-1:0]      bin_q, bin_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              lz_q, lz_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              ovfo_q, ovfo_d;

  logic [BW-1:0]     scr_adj;
  logic [BW-1:0]     scr_shift;
  logic [W-1:0]      bin_shift;
  logic              carry_out;
  logic              final_ovf;
  logic [DIGITS-1:0] blank_calc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    assign scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? (scr_q[4*g +: 4] + 4'd3)
                                                          : scr_q[4*g +: 4];
  end

  assign scr_shift = {scr_adj[BW-2:0], bin_q[W-1]};
  assign carry_out = scr_adj[BW-1];
  assign bin_shift = bin_q << 1;
  assign final_ovf = ovf_q | carry_out;

  // A digit goes dark only if it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    blank_calc = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (scr_shift[4*i +: 4] == 4'd0);
      blank_calc[i] = lz_q & ~final_ovf & zero_above;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    lz_d    = lz_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    ovfo_d  = ovfo_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(W);
          ovf_d   = 1'b0;
          lz_d    = lz_blank;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_d = bin_shift;
        scr_d = scr_shift;
        ovf_d = final_ovf;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = final_ovf ? {DIGITS{4'h9}} : scr_shift;
          blank_d = blank_calc;
          ovfo_d  = final_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      lz_q    <= 1'b0;
      bcd_q   <= '0;
      blank_q <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      lz_q    <= lz_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bcd_out   = bcd_q;
  assign overflow  = ovfo_q;
  assign dbg_state = state_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bin2bcd_seq_seg7 #(
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_seg7 (
      .bcd_i   (bcd_q[4*g +: 4]),
      .blank_i (blank_q[g]),
      .seg_o   (seg_out[7*g +: 7])
    );
  end

endmodule
